seq_divider_8b: RTL and testbench

SEQ_DIVIDER_8B -- requirements
Module: seq_divider_8b

---
 rtl/seq_divider_8b.sv | 110 +++++++++++
 tb/tb_seq_divider_8b.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8b.sv
// seq_divider_8b: unsigned 8-bit / 4-bit restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_ZERO_CHECK_EN to short-circuit y=0 into DONE one cycle after start with dbz=1.
module seq_divider_8b (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       dbz
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    logic [7:0] xr;
    logic [3:0] yr;
    logic [4:0] pr;
    logic [2:0] cnt;
    logic [6:0] qw;

    logic [4:0] pr_shift;
    logic [4:0] pr_next;
    logic       q_bit;
    logic       dz_skip;

    // pr[4] is the bit shifted out; if set, the widened value already exceeds any divisor.
    always_comb begin
        pr_shift = {pr[3:0], xr[~cnt]};
        q_bit    = pr[4] | (pr_shift >= {1'b0, yr});
        pr_next  = q_bit ? (pr_shift - {1'b0, yr}) : pr_shift;
    end

`ifdef DIV_ZERO_CHECK_EN
    always_comb dz_skip = (yr == 4'd0);
`else
    always_comb dz_skip = 1'b0;
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            xr    <= '0;
            yr    <= '0;
            pr    <= '0;
            cnt   <= '0;
            qw    <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dbz   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        xr    <= x;
                        yr    <= y;
                        pr    <= '0;
                        cnt   <= '0;
                        qw    <= '0;
                        state <= CALC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    if (dz_skip) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        q     <= 8'hFF;
                        r     <= xr[3:0];
`ifdef DIV_ZERO_CHECK_EN
                        dbz   <= 1'b1;
`endif
                    end else begin
                        pr  <= pr_next;
                        qw  <= {qw[5:0], q_bit};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            q     <= {qw, q_bit};
                            r     <= pr_next[3:0];
`ifdef DIV_ZERO_CHECK_EN
                            dbz   <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_8b.sv
// Scoreboard bench for seq_divider_8b: directed operands, expected results queued at issue time.
module tb_seq_divider_8b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x = '0;
    logic [3:0] y = '0;
    logic       busy, done, dbz;
    logic [7:0] q;
    logic [3:0] r;

    typedef struct {
        logic [7:0]  q;
        logic [3:0]  r;
        logic        dbz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned base;
    int unsigned c0;
    logic        prev_done = 1'b0;

`ifdef DIV_ZERO_CHECK_EN
    localparam logic        DZ     = 1'b1;
    localparam int unsigned DZ_LAT = 1;
`else
    localparam logic        DZ     = 1'b0;
    localparam int unsigned DZ_LAT = 8;
`endif

    seq_divider_8b dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_width", prev_done, 1'b0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("q", q, e.q);
                check("r", r, e.r);
                check("dbz", dbz, e.dbz);
                check("done_cycle", cyc, e.cyc);
            end
        end
        prev_done = done;
    end

    task automatic wait_results();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_div(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                          input logic [3:0] er, input logic edz, input int unsigned lat);
        @(negedge clk);
        start = 1'b1;
        x     = a;
        y     = b;
        sb.push_back('{eq, er, edz, cyc + 1 + lat});
        @(negedge clk);
        start = 1'b0;
        if (b != 4'd0) check("busy_calc", busy, 1'b1);
        wait_results();
        check("hold_q", q, eq);
        check("hold_r", r, er);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", q, 8'd0);
        check("rst_r", r, 4'd0);
        check("rst_dbz", dbz, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        do_div(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8);
        do_div(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8);
        do_div(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8);
        do_div(8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 8);
        do_div(8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8);
        do_div(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8);
        do_div(8'd250, 4'd11, 8'd22,  4'd8, 1'b0, 8);
        do_div(8'd13,  4'd13, 8'd1,   4'd0, 1'b0, 8);
        do_div(8'd77,  4'd0,  8'hFF,  4'd13, DZ, DZ_LAT);
        do_div(8'd240, 4'd0,  8'hFF,  4'd0,  DZ, DZ_LAT);

        // start with new operands on busy cycles 2..7 is ignored
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        x     = 8'd200;
        y     = 4'd7;
        sb.push_back('{8'd28, 4'd4, 1'b0, cyc + 9});
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            start = 1'b1;
            x     = 8'd99;
            y     = 4'd2;
        end
        @(negedge clk);
        start = 1'b0;
        wait_results();
        repeat (10) @(negedge clk);
        check("single_done", done_cnt - base, 1);

        // back-to-back: start held through DONE with a second operand pair
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        x     = 8'd100;
        y     = 4'd3;
        c0    = cyc;
        sb.push_back('{8'd33, 4'd1, 1'b0, c0 + 9});
        sb.push_back('{8'd11, 4'd1, 1'b0, c0 + 18});
        @(negedge clk);
        x = 8'd45;
        y = 4'd4;
        repeat (8) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_results();
        check("b2b_done_count", done_cnt - base, 2);

        // asynchronous reset during CALC cycle 4 discards the operation
        @(negedge clk);
        start = 1'b1;
        x     = 8'd200;
        y     = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_q", q, 8'd0);
        check("midrst_r", r, 4'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_dbz", dbz, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = done_cnt;
        repeat (15) @(negedge clk);
        check("no_done_after_rst", done_cnt - base, 0);
        do_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
